// File: rtl/rn_sched.sv
// rn_sched: arbitrates slot-load / RN16 / handle-reply requests and serializes 16-bit replies MSB-first.
// Optional slot counter enabled by defining RN_SCHED_SLOT_EN.
module rn_sched (
    input  logic        reset,
    input  logic        rngbitoutclk,
    input  logic [15:0] rn,
    input  logic [3:0]  q,
    input  logic        slotreq,
    input  logic        rn16req,
    input  logic        hdlreq,
    input  logic        slotdec,
    input  logic        abort,
    output logic        ack,
    output logic        busy,
    output logic        txbit,
    output logic        txvalid,
    output logic        txdone,
    output logic [15:0] handle,
    output logic [14:0] slotcnt,
    output logic        slotzero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d, handle_q, handle_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        ack_q, ack_d, txvalid_q, txvalid_d, txdone_q, txdone_d;
    logic        idle, slot_go, hdl_go, rn_go, reply_go, shifting, last_bit;
    assign idle     = state_q == IDLE;
    assign hdl_go   = idle && hdlreq && !slot_go;
    assign rn_go    = idle && rn16req && !slot_go && !hdlreq;
    assign reply_go = hdl_go || rn_go;
    assign last_bit = state_q == SHIFT && !abort && bitcnt_q == 4'd0;
    assign shifting = state_q == SHIFT && !abort && bitcnt_q != 4'd0;
`ifdef RN_SCHED_SLOT_EN
    logic [14:0] slotcnt_q, slotcnt_d;
    assign slot_go = idle && slotreq;
    always_comb begin
        slotcnt_d = slot_go ? rn[14:0] & ((15'd1 << q) - 15'd1)
                  : slotdec ? slotcnt_q - 15'd1 : slotcnt_q;
    end
    always_ff @(posedge rngbitoutclk or posedge reset) begin
        if (reset) slotcnt_q <= '0;
        else       slotcnt_q <= slotcnt_d;
    end
    assign slotcnt = slotcnt_q;
`else
    logic slot_unused;
    assign slot_go     = 1'b0;
    assign slot_unused = ^{q, slotreq, slotdec};
    assign slotcnt     = '0;
`endif
    always_ff @(posedge rngbitoutclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            handle_q  <= '0;
            ack_q     <= 1'b0;
            txvalid_q <= 1'b0;
            txdone_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            handle_q  <= handle_d;
            ack_q     <= ack_d;
            txvalid_q <= txvalid_d;
            txdone_q  <= txdone_d;
        end
    end
    // abort out of SHIFT takes precedence over finishing the last bit
    always_comb begin
        state_d = reply_go ? SHIFT
                : state_q == SHIFT ? (abort ? IDLE : bitcnt_q == 4'd0 ? DONE : SHIFT)
                : IDLE;
    end
    always_comb begin
        shreg_d   = rn_go ? rn : hdl_go ? handle_q : shifting ? shreg_q << 1 : shreg_q;
        bitcnt_d  = reply_go ? 4'd15 : shifting ? bitcnt_q - 4'd1 : bitcnt_q;
        handle_d  = rn_go ? rn : handle_q;
        ack_d     = slot_go || reply_go;
        txvalid_d = reply_go ? 1'b1 : state_q == SHIFT && (abort || bitcnt_q == 4'd0) ? 1'b0 : txvalid_q;
        txdone_d  = last_bit;
    end
    always_comb begin
        busy     = state_q != IDLE;
        txbit    = shreg_q[15];
        ack      = ack_q;
        txvalid  = txvalid_q;
        txdone   = txdone_q;
        handle   = handle_q;
        slotzero = slotcnt == 15'd0;
    end
endmodule

// File: tb/tb_rn_sched.sv
// tb_rn_sched: directed and randomized checks of rn_sched against a word-level reference model.
module tb_rn_sched;
    logic        reset, clk;
    logic [15:0] rn;
    logic [3:0]  q;
    logic        slotreq, rn16req, hdlreq, slotdec, abort;
    logic        ack, busy, txbit, txvalid, txdone, slotzero;
    logic [15:0] handle;
    logic [14:0] slotcnt;
    int          checks = 0, errors = 0;
    logic [15:0] m_handle = '0;
    int          m_slot = 0;

    rn_sched dut (
        .reset(reset), .rngbitoutclk(clk), .rn(rn), .q(q), .slotreq(slotreq),
        .rn16req(rn16req), .hdlreq(hdlreq), .slotdec(slotdec), .abort(abort),
        .ack(ack), .busy(busy), .txbit(txbit), .txvalid(txvalid), .txdone(txdone),
        .handle(handle), .slotcnt(slotcnt), .slotzero(slotzero)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_txbit"}, txbit, 0);
        chk({tag, "_txvalid"}, txvalid, 0);
        chk({tag, "_txdone"}, txdone, 0);
        chk({tag, "_handle"}, handle, 0);
        chk({tag, "_slotcnt"}, slotcnt, 0);
        chk({tag, "_slotzero"}, slotzero, 1);
    endtask

    // one full or aborted reply; abort_at < 0 means run to completion
    task automatic reply(input bit use_hdl, input logic [15:0] rv, input int abort_at);
        logic [15:0] word;
        word    = use_hdl ? m_handle : rv;
        rn      = rv;
        hdlreq  = use_hdl;
        rn16req = !use_hdl;
        tick;
        chk("grant_ack", ack, 1);
        hdlreq  = 0;
        rn16req = 0;
        if (!use_hdl) m_handle = rv;
        for (int i = 0; i < 16; i++) begin
            chk("txvalid", txvalid, 1);
            chk("txbit", txbit, word[15-i]);
            if (i == abort_at) begin
                abort = 1;
                tick;
                abort = 0;
                chk("abort_txvalid", txvalid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_txdone", txdone, 0);
                chk("abort_handle", handle, m_handle);
                tick;
                chk("abort_txdone2", txdone, 0);
                return;
            end
            tick;
            if (i == 0) chk("ack_pulse", ack, 0);
        end
        chk("end_txvalid", txvalid, 0);
        chk("txdone", txdone, 1);
        chk("done_busy", busy, 1);
        tick;
        chk("txdone_pulse", txdone, 0);
        chk("back_idle", busy, 0);
        chk("handle", handle, m_handle);
    endtask

    task automatic slot_load(input logic [3:0] qv, input logic [15:0] rv, input bit dec_too);
        q = qv; rn = rv; slotreq = 1; slotdec = dec_too;
        tick;
        slotreq = 0; slotdec = 0;
`ifdef RN_SCHED_SLOT_EN
        m_slot = int'(rv[14:0]) % (1 << qv);
        chk("slot_ack", ack, 1);
`else
        chk("noslot_ack", ack, 0);
`endif
        chk("slot_busy", busy, 0);
        chk("slotcnt_load", slotcnt, m_slot);
        chk("slotzero_load", slotzero, m_slot == 0);
    endtask

    task automatic slot_dec;
        slotdec = 1;
        tick;
        slotdec = 0;
`ifdef RN_SCHED_SLOT_EN
        m_slot = (m_slot + 32767) % 32768;
`endif
        chk("slotcnt_dec", slotcnt, m_slot);
        chk("slotzero_dec", slotzero, m_slot == 0);
    endtask

    initial begin
        reset = 1; rn = 0; q = 0; slotreq = 0; rn16req = 0; hdlreq = 0; slotdec = 0; abort = 0;
        tick; tick;
        chk_reset_vals("reset");
        reset = 0;
        tick;
        chk("idle_busy", busy, 0);

        reply(0, 16'hA5C3, -1);
        reply(1, 16'h0000, -1);

        slot_load(4'd4, 16'hFFFF, 0);
        repeat (5) slot_dec;
        slot_load(4'd0, 16'hFFFF, 0);
        slot_dec;
        slot_load(4'd15, 16'h8001, 1);
        slot_load(4'd15, 16'h0000, 0);
        slot_dec;

        // all three requests at once
        rn = 16'h1234; q = 4'd3; slotreq = 1; hdlreq = 1; rn16req = 1;
`ifdef RN_SCHED_SLOT_EN
        tick;
        m_slot = 4;
        chk("prio_slot_ack", ack, 1);
        chk("prio_slot_busy", busy, 0);
        chk("prio_slotcnt", slotcnt, m_slot);
`endif
        slotreq = 0;
        if (ack !== 1'b1 || busy !== 1'b1) tick;
        chk("prio_hdl_ack", ack, 1);
        chk("prio_hdl_busy", busy, 1);
        chk("prio_hdl_bit", txbit, m_handle[15]);
        hdlreq = 0;
        repeat (16) tick;
        chk("prio_txdone", txdone, 1);
        chk("prio_no_rn_ack", ack, 0);
        tick;
        chk("prio_wait_ack", ack, 0);
        chk("prio_wait_busy", busy, 0);
        tick;
        chk("prio_rn_ack", ack, 1);
        chk("prio_rn_bit", txbit, rn[15]);
        m_handle = rn;
        rn16req = 0;
        repeat (16) tick;
        chk("prio_rn_txdone", txdone, 1);
        tick;
        chk("prio_handle", handle, m_handle);

        reply(0, 16'h3C5A, 5);
        reply(1, 16'hFFFF, -1);

        for (int n = 0; n < 24; n++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            reply($urandom_range(0, 1) == 1, 16'($urandom), ab);
            slot_load(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) slot_dec;
        end

        // asynchronous reset in the middle of a reply
        rn = 16'hBEEF; rn16req = 1;
        tick;
        rn16req = 0;
        repeat (4) tick;
        chk("pre_reset_valid", txvalid, 1);
        #1 reset = 1;
        #1;
        chk_reset_vals("async_reset");
        m_handle = '0;
        m_slot = 0;
        tick;
        reset = 0;
        tick;
        reply(0, 16'h8421, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
